// File: rtl/dram_pkg.sv
// Shared types and widths for the DRAM command/response path.
// Also holds the saturating in-flight counter update used by the throttle.
package dram_pkg;

  localparam int DRAM_WORDS  = 16;
  localparam int DRAM_WORD_W = 32;
  localparam int DRAM_ADDR_W = 64;
  localparam int DRAM_TAG_W  = 32;
  localparam int DRAM_DATA_W = DRAM_WORDS * DRAM_WORD_W;

  typedef struct packed {
    logic [DRAM_ADDR_W-1:0] addr;
    logic                   isWr;
    logic [DRAM_TAG_W-1:0]  tag;
    logic [31:0]            streamId;
    logic [DRAM_DATA_W-1:0] wdata;
  } dram_cmd_t;

  typedef struct packed {
    logic [DRAM_TAG_W-1:0]  tag;
    logic [31:0]            streamId;
    logic [DRAM_DATA_W-1:0] rdata;
  } dram_resp_t;

  // Simultaneous increment and decrement cancel; decrement never wraps below 0.
  function automatic logic [7:0] credit_next(input logic [7:0] cur,
                                             input logic       inc,
                                             input logic       dec);
    logic [7:0] nxt;
    nxt = cur;
    if (inc && !dec) begin
      nxt = cur + 8'd1;
    end else if (dec && !inc) begin
      nxt = (cur == 8'd0) ? 8'd0 : cur - 8'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/dram_resp_fifo.sv
// Synchronous response FIFO with no bypass: a push into an empty FIFO is
// visible at the head one cycle later. Full/empty come straight from registers.
module dram_resp_fifo
  import dram_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  dram_resp_t       push_data,
  input  logic             pop,
  output dram_resp_t       head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  dram_resp_t       mem_q [DEPTH];
  dram_resp_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dram_cmd_throttle.sv
// Registers DRAM commands, limits in-flight requests to MAX_OUTSTANDING and
// buffers responses; keeps handshake counters and a sticky underflow flag.
module dram_cmd_throttle
  import dram_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  parameter int RESP_DEPTH      = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  // valid/ready: a transfer happens on a rising edge where both are high;
  // valid, once raised, holds with a stable payload until that transfer.
  input  logic                   cmd_in_valid,
  output logic                   cmd_in_ready,
  input  logic [DRAM_ADDR_W-1:0] cmd_in_addr,
  input  logic                   cmd_in_isWr,
  input  logic [DRAM_TAG_W-1:0]  cmd_in_tag,
  input  logic [31:0]            cmd_in_streamId,
  input  logic [DRAM_DATA_W-1:0] cmd_in_wdata,
  output logic                   cmd_out_valid,
  input  logic                   cmd_out_ready,
  output logic [DRAM_ADDR_W-1:0] cmd_out_addr,
  output logic                   cmd_out_isWr,
  output logic [DRAM_TAG_W-1:0]  cmd_out_tag,
  output logic [31:0]            cmd_out_streamId,
  output logic [DRAM_DATA_W-1:0] cmd_out_wdata,
  input  logic                   resp_in_valid,
  output logic                   resp_in_ready,
  input  logic [DRAM_TAG_W-1:0]  resp_in_tag,
  input  logic [31:0]            resp_in_streamId,
  input  logic [DRAM_DATA_W-1:0] resp_in_rdata,
  output logic                   resp_out_valid,
  input  logic                   resp_out_ready,
  output logic [DRAM_TAG_W-1:0]  resp_out_tag,
  output logic [31:0]            resp_out_streamId,
  output logic [DRAM_DATA_W-1:0] resp_out_rdata,
  output logic [7:0]             outstanding,
  output logic [31:0]            cmd_count,
  output logic [31:0]            resp_count,
  output logic                   err_underflow
);

  localparam int         CNT_W = $clog2(RESP_DEPTH) + 1;
  localparam logic [7:0] MAX_L = 8'(MAX_OUTSTANDING);

  dram_cmd_t   cmd_q, cmd_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  outstanding_q, outstanding_d;
  logic [31:0] cmd_count_q, cmd_count_d;
  logic [31:0] resp_count_q, resp_count_d;
  logic        err_q, err_d;

  dram_resp_t       resp_push_data, resp_head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             cmd_in_fire, cmd_out_fire, resp_in_fire, resp_out_fire;

  assign cmd_in_ready  = (!cmd_valid_q || cmd_out_ready) && (outstanding_q < MAX_L);
  assign cmd_in_fire   = cmd_in_valid && cmd_in_ready;
  assign cmd_out_fire  = cmd_valid_q && cmd_out_ready;
  assign resp_in_ready = !fifo_full;
  assign resp_in_fire  = resp_in_valid && !fifo_full;
  assign resp_out_fire = !fifo_empty && resp_out_ready;

  assign resp_push_data = '{tag: resp_in_tag, streamId: resp_in_streamId, rdata: resp_in_rdata};

  dram_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (resp_in_valid),
    .push_data (resp_push_data),
    .pop       (resp_out_ready),
    .head      (resp_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    cmd_d         = cmd_q;
    cmd_valid_d   = cmd_valid_q;
    outstanding_d = credit_next(outstanding_q, cmd_in_fire, resp_out_fire);
    cmd_count_d   = cmd_count_q + (cmd_out_fire ? 32'd1 : 32'd0);
    resp_count_d  = resp_count_q + (resp_out_fire ? 32'd1 : 32'd0);
    err_d         = err_q;
    if (cmd_in_fire) begin
      cmd_d       = '{addr: cmd_in_addr, isWr: cmd_in_isWr, tag: cmd_in_tag,
                      streamId: cmd_in_streamId, wdata: cmd_in_wdata};
      cmd_valid_d = 1'b1;
    end else if (cmd_out_fire) begin
      cmd_valid_d = 1'b0;
    end
    // Responses already queued have consumed their command's credit, so an
    // arrival is unmatched once the queue holds as many as are in flight.
    if (resp_in_fire && (outstanding_q <= 8'(fifo_count))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q         <= '0;
      cmd_valid_q   <= 1'b0;
      outstanding_q <= 8'd0;
      cmd_count_q   <= 32'd0;
      resp_count_q  <= 32'd0;
      err_q         <= 1'b0;
    end else begin
      cmd_q         <= cmd_d;
      cmd_valid_q   <= cmd_valid_d;
      outstanding_q <= outstanding_d;
      cmd_count_q   <= cmd_count_d;
      resp_count_q  <= resp_count_d;
      err_q         <= err_d;
    end
  end

  assign cmd_out_valid     = cmd_valid_q;
  assign cmd_out_addr      = cmd_q.addr;
  assign cmd_out_isWr      = cmd_q.isWr;
  assign cmd_out_tag       = cmd_q.tag;
  assign cmd_out_streamId  = cmd_q.streamId;
  assign cmd_out_wdata     = cmd_q.wdata;
  assign resp_out_valid    = !fifo_empty;
  assign resp_out_tag      = resp_head.tag;
  assign resp_out_streamId = resp_head.streamId;
  assign resp_out_rdata    = resp_head.rdata;
  assign outstanding       = outstanding_q;
  assign cmd_count         = cmd_count_q;
  assign resp_count        = resp_count_q;
  assign err_underflow     = err_q;

endmodule
